// File: rtl/system_mode_controller.sv
// system_mode_controller: sequences LOAD/RUN/DUMP commands into system memory mode strobes
// and frames the memory's serial output into a valid-qualified stream.
module system_mode_controller #(
  parameter int DATA_SIZE = 64,
  parameter int GEN_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 CMD_VALID,
  output logic                 CMD_READY,
  input  logic [1:0]           CMD_OP,
  input  logic [GEN_WIDTH-1:0] CMD_GENS,
  input  logic                 EXT_BIT_IN,
  input  logic                 EXT_BIT_VALID,
  output logic                 EXT_BIT_READY,
  output logic                 EXT_OUT_BIT,
  output logic                 EXT_OUT_VALID,
  input  logic                 MEM_SERIAL_OUT,
  output logic                 SERIAL_IN,
  output logic                 LOAD_MODE,
  output logic                 RUN_MODE,
  output logic                 OUTPUT_MODE,
  output logic                 BUSY,
  output logic                 DONE
);
  localparam int CW = $clog2(DATA_SIZE + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_SIZE - 1);
  typedef enum logic [2:0] {IDLE, LOAD, RUN, DUMP, DRAIN} state_t;
  state_t state;
  logic [CW-1:0] bitcnt;
  logic [GEN_WIDTH-1:0] gencnt;
  logic accept;
  assign CMD_READY     = state == IDLE;
  assign BUSY          = ~CMD_READY;
  assign accept        = CMD_VALID & CMD_READY;
  assign EXT_BIT_READY = state == LOAD;
  assign LOAD_MODE     = (state == LOAD) & EXT_BIT_VALID;
  assign RUN_MODE      = state == RUN;
  assign OUTPUT_MODE   = state == DUMP;
  assign SERIAL_IN     = EXT_BIT_IN;
  assign EXT_OUT_BIT   = MEM_SERIAL_OUT;
  // Memory SERIAL_OUT is registered, so the stream lags OUTPUT_MODE by one cycle.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state         <= IDLE;
      bitcnt        <= '0;
      gencnt        <= '0;
      EXT_OUT_VALID <= 1'b0;
      DONE          <= 1'b0;
    end else begin
      EXT_OUT_VALID <= OUTPUT_MODE;
      DONE          <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          bitcnt <= '0;
          case (CMD_OP)
            2'b01: state <= LOAD;
            2'b10: if (CMD_GENS == '0) DONE <= 1'b1;
                   else begin
                     state  <= RUN;
                     gencnt <= CMD_GENS;
                   end
            2'b11: state <= DUMP;
            default: DONE <= 1'b1;
          endcase
        end
        LOAD: if (EXT_BIT_VALID) begin
          bitcnt <= bitcnt + 1'b1;
          if (bitcnt == LAST) begin
            state <= IDLE;
            DONE  <= 1'b1;
          end
        end
        RUN: begin
          gencnt <= gencnt - 1'b1;
          if (gencnt == GEN_WIDTH'(1)) begin
            state <= IDLE;
            DONE  <= 1'b1;
          end
        end
        DUMP: begin
          bitcnt <= bitcnt + 1'b1;
          if (bitcnt == LAST) state <= DRAIN;
        end
        DRAIN: begin
          state <= IDLE;
          DONE  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_system_mode_controller.sv
// tb_system_mode_controller: directed and randomised checks with an attached 8-bit system memory
// and a grid-level reference model.
module tb_system_mode_controller;
  localparam int DS = 8;
  localparam int GW = 16;
  logic CLK = 1'b0, RESET_N = 1'b1, CMD_VALID = 1'b0;
  logic [1:0] CMD_OP = '0;
  logic [GW-1:0] CMD_GENS = '0;
  logic EXT_BIT_IN = 1'b0, EXT_BIT_VALID = 1'b0;
  logic MEM_SERIAL_OUT;
  logic CMD_READY, EXT_BIT_READY, EXT_OUT_BIT, EXT_OUT_VALID, SERIAL_IN;
  logic LOAD_MODE, RUN_MODE, OUTPUT_MODE, BUSY, DONE;

  system_mode_controller #(.DATA_SIZE(DS), .GEN_WIDTH(GW)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_OP(CMD_OP), .CMD_GENS(CMD_GENS), .EXT_BIT_IN(EXT_BIT_IN),
    .EXT_BIT_VALID(EXT_BIT_VALID), .EXT_BIT_READY(EXT_BIT_READY),
    .EXT_OUT_BIT(EXT_OUT_BIT), .EXT_OUT_VALID(EXT_OUT_VALID),
    .MEM_SERIAL_OUT(MEM_SERIAL_OUT), .SERIAL_IN(SERIAL_IN), .LOAD_MODE(LOAD_MODE),
    .RUN_MODE(RUN_MODE), .OUTPUT_MODE(OUTPUT_MODE), .BUSY(BUSY), .DONE(DONE));

  always #5 CLK = ~CLK;

  // System memory: shift-in load, one generation per RUN cycle, circular registered readout.
  logic [7:0] mem = '0;
  logic mem_so = 1'b0;
  assign MEM_SERIAL_OUT = mem_so;
  always @(posedge CLK) begin
    if (LOAD_MODE) mem <= {mem[6:0], SERIAL_IN};
    else if (RUN_MODE) mem <= mem ^ {mem[6:0], mem[7]};
    else if (OUTPUT_MODE) begin
      mem_so <= mem[7];
      mem    <= {mem[6:0], mem[7]};
    end
  end

  int checks = 0, errors = 0, cyc = 0, acc = 0, rel = 0;
  int load_n, run_n, dump_n, first_v, last_v;
  bit q[$];
  logic [7:0] ref_grid = '0;
  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    checks++;
    assert ($countones({LOAD_MODE, RUN_MODE, OUTPUT_MODE}) <= 1) else begin
      errors++;
      $error("FAIL onehot obs=%b exp=at_most_one_hot", {LOAD_MODE, RUN_MODE, OUTPUT_MODE});
    end
    checks++;
    assert (BUSY === ~CMD_READY) else begin
      errors++;
      $error("FAIL busy obs=%b exp=%b", BUSY, ~CMD_READY);
    end
    if (LOAD_MODE) load_n++;
    if (RUN_MODE) run_n++;
    if (OUTPUT_MODE) dump_n++;
    if (EXT_OUT_VALID) begin
      q.push_back(EXT_OUT_BIT);
      if (first_v < 0) first_v = cyc;
      last_v = cyc;
    end
  end

  function automatic logic [7:0] gen(input logic [7:0] g);
    int v = int'(g);
    return 8'((v ^ (v << 1) ^ (v >> 7)) & 255);
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    load_n = 0; run_n = 0; dump_n = 0; first_v = -1; last_v = -1;
    q.delete();
  endtask

  task automatic issue(input logic [1:0] op, input int gens);
    int n = 0;
    while (CMD_READY !== 1'b1 && n < 200) begin tick(); n++; end
    chk("ready_wait", 32'(n < 200), 1);
    CMD_VALID = 1'b1; CMD_OP = op; CMD_GENS = GW'(gens);
    clear_mon();
    tick();
    CMD_VALID = 1'b0;
    acc = cyc;
  endtask

  task automatic wait_done();
    int n = 0;
    while (DONE !== 1'b1 && n < 200) begin tick(); n++; end
    chk("done_timeout", 32'(n < 200), 1);
    rel = cyc - acc + 1;
  endtask

  task automatic send_bits(input logic [7:0] d, input int gap);
    for (int i = 7; i >= 0; i--) begin
      EXT_BIT_IN = d[i]; EXT_BIT_VALID = 1'b1;
      tick();
      EXT_BIT_VALID = 1'b0; EXT_BIT_IN = 1'($urandom);
      if (i > 0) repeat (gap < 0 ? $urandom_range(2) : gap) tick();
    end
  endtask

  task automatic do_load(input logic [7:0] d, input int gap);
    issue(2'b01, 0);
    chk("bit_ready", 32'(EXT_BIT_READY), 1);
    send_bits(d, gap);
    chk("load_done", 32'(DONE), 1);
    chk("load_cycles", load_n, DS);
    ref_grid = d;
    tick();
    chk("load_done_pulse", 32'(DONE), 0);
    chk("load_mem", 32'(mem), 32'(ref_grid));
  endtask

  task automatic do_run(input int g);
    issue(2'b10, g);
    wait_done();
    chk("run_cycles", run_n, g);
    chk("run_done_cycle", rel, g + 1);
    repeat (g) ref_grid = gen(ref_grid);
    tick();
    chk("run_done_pulse", 32'(DONE), 0);
    chk("run_mem", 32'(mem), 32'(ref_grid));
  endtask

  task automatic check_dump();
    logic [7:0] got = '0;
    wait_done();
    foreach (q[i]) got = {got[6:0], q[i]};
    chk("dump_done_cycle", rel, DS + 2);
    chk("dump_mode_cycles", dump_n, DS);
    chk("dump_len", q.size(), DS);
    chk("dump_first_valid", first_v - acc + 1, 2);
    chk("dump_last_valid", last_v - acc + 1, DS + 1);
    chk("dump_stream", 32'(got), 32'(ref_grid));
    tick();
    chk("dump_done_pulse", 32'(DONE), 0);
    chk("dump_mem", 32'(mem), 32'(ref_grid));
  endtask

  task automatic do_dump();
    issue(2'b11, 0);
    check_dump();
  endtask

  initial begin
    #2 RESET_N = 1'b0;
    tick();
    tick();
    RESET_N = 1'b1;
    tick();
    chk("rst_ready", 32'(CMD_READY), 1);
    chk("rst_bit_ready", 32'(EXT_BIT_READY), 0);
    chk("rst_modes", 32'({LOAD_MODE, RUN_MODE, OUTPUT_MODE}), 0);
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_done", 32'(DONE), 0);
    chk("rst_out_valid", 32'(EXT_OUT_VALID), 0);

    do_load(8'hA5, 1);
    do_dump();
    do_dump();
    do_run(3);
    do_run(0);
    issue(2'b00, 0);
    chk("nop_done", 32'(DONE), 1);

    // CMD_VALID held through a LOAD; queued DUMP must only be taken in the DONE cycle.
    do_load(8'hA5, 0);
    CMD_VALID = 1'b1; CMD_OP = 2'b01;
    clear_mon();
    tick();
    acc = cyc;
    CMD_OP = 2'b11;
    chk("b2b_busy", 32'(CMD_READY), 0);
    send_bits(8'h3C, 0);
    chk("b2b_load_cycles", load_n, DS);
    chk("b2b_no_early_dump", dump_n, 0);
    chk("b2b_done", 32'(DONE), 1);
    chk("b2b_ready_in_done", 32'(CMD_READY), 1);
    ref_grid = 8'h3C;
    clear_mon();
    tick();
    CMD_VALID = 1'b0;
    acc = cyc;
    chk("b2b_dump_started", 32'(OUTPUT_MODE), 1);
    check_dump();

    issue(2'b11, 0);
    repeat (3) tick();
    RESET_N = 1'b0;
    #1;
    chk("abort_modes", 32'({LOAD_MODE, RUN_MODE, OUTPUT_MODE}), 0);
    chk("abort_out_valid", 32'(EXT_OUT_VALID), 0);
    chk("abort_done", 32'(DONE), 0);
    tick();
    RESET_N = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("abort_ready", 32'(CMD_READY), 1);
      chk("abort_no_done", 32'(DONE), 0);
    end

    do_load(8'($urandom), -1);
    for (int i = 0; i < 25; i++) begin
      case ($urandom_range(2))
        0: do_load(8'($urandom), -1);
        1: do_run(int'($urandom_range(5)));
        default: do_dump();
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
